// File: rtl/constants_pkg.sv
// Shared widths, depths and record types for the memory responder.
package constants_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int RSP_DEPTH  = 4;
  localparam int LATENCY    = 2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } rsp_stage_t;

endpackage

// File: rtl/rsp_fifo.sv
// Circular response FIFO with wrap-bit pointers and a registered head word,
// so the consumer sees a flop output that only changes on push-into-empty or pop.
module rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]      rd_next;
  logic [PW:0]      count;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_next = rd_ptr_q + PTR_ONE;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = head_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_next            : rd_ptr_q;
    head_d   = head_q;
    if (do_pop) begin
      if (count > PTR_ONE)  head_d = mem_q[rd_next[PW-1:0]];
      else if (do_push)     head_d = push_data_i;
    end else if (empty_o && do_push) begin
      head_d = push_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: synchronous SRAM, fixed-latency read pipeline and
// credit-limited in-order response FIFO.
module mem_responder #(
  parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = constants_pkg::ADDR_WIDTH,
  parameter int LATENCY    = constants_pkg::LATENCY,
  parameter int RSP_DEPTH  = constants_pkg::RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req_vld,
  output logic                  m_req_rdy,
  input  logic                  m_req_we,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  input  logic [DATA_WIDTH-1:0] m_req_wdata,
  output logic                  m_rsp_vld,
  input  logic                  m_rsp_rdy,
  output logic [DATA_WIDTH-1:0] m_rsp_data
);

  localparam int MEM_WORDS = 1 << ADDR_WIDTH;
  localparam int CW        = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  logic [DATA_WIDTH-1:0] sram_q [MEM_WORDS];
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic                  req_acc, rd_acc, wr_acc, rsp_hs;
  logic                  fifo_empty, fifo_full;
  stage_t                rd_stage, tail;

  assign req_acc   = m_req_vld && m_req_rdy;
  assign rd_acc    = req_acc && !m_req_we;
  assign wr_acc    = req_acc && m_req_we;
  assign rsp_hs    = m_rsp_vld && m_rsp_rdy;
  // Depends on registered state only, so a credit freed by a pop shows up next cycle.
  assign m_req_rdy = (outstanding_q != CNT_FULL);
  assign m_rsp_vld = !fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_acc) sram_q[m_req_addr] <= m_req_wdata;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_acc && !rsp_hs)      outstanding_d = outstanding_q + CNT_ONE;
    else if (!rd_acc && rsp_hs) outstanding_d = outstanding_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) outstanding_q <= '0;
    else        outstanding_q <= outstanding_d;
  end

  assign rd_stage.vld  = rd_acc;
  assign rd_stage.data = sram_q[m_req_addr];

  // The FIFO entry itself is the last latency stage, so only LATENCY-1 shift stages precede it.
  if (LATENCY == 1) begin : g_direct
    assign tail = rd_stage;
  end else begin : g_pipe
    stage_t pipe_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY-1; i++) pipe_q[i].vld <= 1'b0;
      end else begin
        pipe_q[0] <= rd_stage;
        for (int i = 1; i < LATENCY-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign tail = pipe_q[LATENCY-2];
  end

  rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tail.vld),
    .push_data_i (tail.data),
    .pop_i       (rsp_hs),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (m_rsp_data)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(tail.vld && fifo_full && !rsp_hs));

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a transaction-level model
// (model memory, expected-response queue, outstanding-read count).
module tb_mem_responder;
  import constants_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_vld, req_rdy, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_data;

  always #5 clk = ~clk;

  mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req_vld   (req_vld),
    .m_req_rdy   (req_rdy),
    .m_req_we    (req_we),
    .m_req_addr  (req_addr),
    .m_req_wdata (req_wdata),
    .m_rsp_vld   (rsp_vld),
    .m_rsp_rdy   (rsp_rdy),
    .m_rsp_data  (rsp_data)
  );

  logic [DW-1:0] model_mem [1 << AW];
  logic [DW-1:0] exp_q [$];
  int            outstanding;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  int            checks;
  int            passes;

  task automatic issue(input mem_req_t r);
    req_vld   = 1'b1;
    req_we    = r.we;
    req_addr  = r.addr;
    req_wdata = r.wdata;
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_req_t r;
    r.we = 1'b1; r.addr = a; r.wdata = d;
    issue(r);
  endtask

  task automatic issue_rd(input logic [AW-1:0] a);
    mem_req_t r;
    r.we = 1'b0; r.addr = a; r.wdata = '0;
    issue(r);
  endtask

  // Called just after a negedge with this cycle's inputs set; returns at the following negedge.
  task automatic tick();
    bit            acc, hs;
    logic [DW-1:0] exp;
    checks++;
    if (req_rdy !== (outstanding < DEPTH))
      $display("FAIL req_rdy: got %b expected %b (outstanding %0d)", req_rdy, outstanding < DEPTH, outstanding);
    else passes++;
    if (prev_stall) begin
      checks++;
      if (rsp_vld !== 1'b1 || rsp_data !== prev_data)
        $display("FAIL rsp_hold: got vld=%b data=%h expected vld=1 data=%h", rsp_vld, rsp_data, prev_data);
      else passes++;
    end
    checks++;
    if (rsp_vld === 1'b1 && exp_q.size() == 0)
      $display("FAIL stale_rsp: got vld=1 data=%h expected no response", rsp_data);
    else passes++;
    acc = req_vld && req_rdy;
    hs  = rsp_vld && rsp_rdy;
    if (hs && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (rsp_data !== exp) $display("FAIL rsp_data: got %h expected %h", rsp_data, exp);
      else passes++;
      outstanding--;
    end
    if (acc) begin
      if (req_we) model_mem[req_addr] = req_wdata;
      else begin
        exp_q.push_back(model_mem[req_addr]);
        outstanding++;
      end
    end
    prev_stall = rsp_vld && !rsp_rdy;
    prev_data  = rsp_data;
    @(posedge clk);
    #1;
    if (acc) req_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    req_vld = 1'b0;
    rst_n   = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    outstanding = 0;
    prev_stall  = 1'b0;
  endtask

  task automatic expect_vld(input string name, input logic v);
    checks++;
    if (rsp_vld !== v) $display("FAIL %s: got vld=%b expected %b", name, rsp_vld, v);
    else passes++;
  endtask

  task automatic expect_rsp(input string name, input logic [DW-1:0] d);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== d)
      $display("FAIL %s: got vld=%b data=%h expected vld=1 data=%h", name, rsp_vld, rsp_data, d);
    else passes++;
  endtask

  task automatic expect_rdy(input string name, input logic v);
    checks++;
    if (req_rdy !== v) $display("FAIL %s: got rdy=%b expected %b", name, req_rdy, v);
    else passes++;
  endtask

  task automatic drain();
    rsp_rdy = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || req_vld); i++) tick();
    checks++;
    if (exp_q.size() != 0 || req_vld)
      $display("FAIL drain: got %0d responses still pending expected 0", exp_q.size());
    else passes++;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    apply_reset(2);
    expect_vld("reset_vld", 1'b0);
    checks++;
    if (rsp_data !== '0) $display("FAIL reset_data: got %h expected 00", rsp_data);
    else passes++;
    expect_rdy("reset_rdy", 1'b1);
  endtask

  task automatic test_write();
    issue_wr(8'h10, 8'hA5);
    tick();
    expect_vld("write_no_rsp", 1'b0);
    expect_rdy("write_rdy", 1'b1);
    repeat (3) tick();
    expect_vld("write_no_rsp_late", 1'b0);
  endtask

  task automatic test_read_latency();
    rsp_rdy = 1'b1;
    issue_rd(8'h10);
    tick();
    expect_vld("lat_early", 1'b0);
    tick();
    expect_rsp("lat_rsp", 8'hA5);
    tick();
    expect_vld("lat_one_cycle", 1'b0);
  endtask

  task automatic test_raw();
    issue_wr(8'h20, 8'h3C);
    tick();
    issue_rd(8'h20);
    tick();
    expect_vld("raw_early", 1'b0);
    tick();
    expect_rsp("raw_rsp", 8'h3C);
    tick();
    expect_vld("raw_done", 1'b0);
  endtask

  task automatic test_backpressure();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_wr(AW'(i), DW'(8'h11 + i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      expect_rdy("bp_rdy_open", 1'b1);
      issue_rd(AW'(i));
      tick();
    end
    issue_rd(8'h04);
    repeat (3) begin
      expect_rdy("bp_rdy_blocked", 1'b0);
      expect_rsp("bp_head", 8'h11);
      tick();
    end
    rsp_rdy = 1'b1;
    for (int i = 0; i < 10 && req_vld; i++) tick();
    checks++;
    if (req_vld !== 1'b0) $display("FAIL bp_fifth_accept: got still pending expected accepted");
    else passes++;
    drain();
  endtask

  task automatic test_full_retire();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_rd(AW'(i));
      tick();
    end
    expect_rdy("full_blocked", 1'b0);
    issue_rd(8'h04);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    expect_rdy("full_credit_freed", 1'b1);
    tick();
    expect_rdy("full_credit_refilled", 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_rd(AW'(i));
      tick();
    end
    apply_reset(1);
    expect_vld("midrst_vld", 1'b0);
    expect_rdy("midrst_rdy", 1'b1);
    rsp_rdy = 1'b1;
    repeat (4) tick();
    expect_vld("midrst_no_stale", 1'b0);
    issue_rd(8'h10);
    tick();
    tick();
    expect_rsp("midrst_read", 8'hA5);
    drain();
  endtask

  task automatic test_back_to_back();
    rsp_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue_wr(AW'(8'h40 + i), DW'($urandom));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      expect_rdy("b2b_rdy", 1'b1);
      if (i >= LAT) expect_vld("b2b_vld", 1'b1);
      issue_rd(AW'(8'h40 + i));
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    mem_req_t r;
    for (int i = 0; i < 400; i++) begin
      if (!req_vld && $urandom_range(0, 9) < 7) begin
        r.we    = ($urandom_range(0, 3) == 0);
        r.addr  = AW'(8'h40 + $urandom_range(0, 15));
        r.wdata = DW'($urandom);
        issue(r);
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    outstanding = 0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    rst_n       = 1'b0;
    req_vld     = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_rdy     = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read_latency();
    test_raw();
    test_backpressure();
    test_full_retire();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
